// File: rtl/lcd_pkg.sv
// Shared constants, state types and step-decode helpers for the HD44780 text controller.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC  = 8'h38;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;

   localparam logic [5:0] STEP_CLEAR     = 6'd2;
   localparam logic [5:0] STEP_INIT_LAST = 6'd3;
   localparam logic [5:0] STEP_WRAP      = 6'd4;
   localparam logic [5:0] STEP_LAST      = 6'd37;

   typedef enum logic [2:0] {BwIdle, BwLoad, BwSetup, BwPulse, BwWait} bw_state_e;
   typedef enum logic {TopPwrup, TopSeq} top_state_e;

   // Steps 5-20 carry line 1 characters, 22-37 line 2 characters.
   function automatic logic step_is_data(logic [5:0] s);
      return ((s >= 6'd5) && (s <= 6'd20)) || (s >= 6'd22);
   endfunction

   function automatic logic [4:0] step_rom_addr(logic [5:0] s);
      return 5'((s <= 6'd20) ? (s - 6'd5) : (s - 6'd6));
   endfunction

   function automatic logic [7:0] step_cmd(logic [5:0] s);
      case (s)
         6'd0:    return CMD_FUNC;
         6'd1:    return CMD_DISP;
         6'd2:    return CMD_CLEAR;
         6'd3:    return CMD_ENTRY;
         6'd4:    return CMD_LINE1;
         6'd21:   return CMD_LINE2;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// Text-ROM address/data pair plus the character-LCD pin bundle.
interface lcd_text_ctrl_if;
   logic [4:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic       lcd_on;
   logic       lcd_blon;

   modport master (
      output rom_addr,
      input  rom_data,
      output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon
   );
endinterface

// File: rtl/lcd_byte_writer.sv
// One LCD write: LOAD, SETUP, enable PULSE, then a fixed post-write WAIT; done pulses on the last
// WAIT cycle and a start in that cycle chains straight into the next LOAD.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int unsigned T_EN    = 1,
   parameter int unsigned T_SHORT = 50,
   parameter int unsigned T_LONG  = 2000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic       rs_i,
   input  logic [7:0] byte_i,
   input  logic       long_wait_i,
   output logic       done_o,
   output logic [7:0] lcd_data_o,
   output logic       lcd_rs_o,
   output logic       lcd_en_o
);

   localparam int unsigned MaxT = (T_LONG > T_SHORT) ? T_LONG : T_SHORT;
   localparam int unsigned CntW = $clog2(((MaxT > T_EN) ? MaxT : T_EN) + 1);

   bw_state_e        state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             long_q, long_d;
   logic             en_q, en_d;
   logic [CntW-1:0]  wait_lim;

   assign wait_lim = long_q ? CntW'(T_LONG - 1) : CntW'(T_SHORT - 1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CntW'(1);
      data_d  = data_q;
      rs_d    = rs_q;
      long_d  = long_q;
      done_o  = 1'b0;
      unique case (state_q)
         BwIdle: begin
            cnt_d = '0;
            if (start_i) state_d = BwLoad;
         end
         BwLoad: begin
            // Byte is captured here so it stays frozen through SETUP, PULSE and WAIT.
            cnt_d   = '0;
            data_d  = byte_i;
            rs_d    = rs_i;
            long_d  = long_wait_i;
            state_d = BwSetup;
         end
         BwSetup: begin
            if (cnt_q == CntW'(T_EN - 1)) begin
               cnt_d   = '0;
               state_d = BwPulse;
            end
         end
         BwPulse: begin
            if (cnt_q == CntW'(T_EN - 1)) begin
               cnt_d   = '0;
               state_d = BwWait;
            end
         end
         BwWait: begin
            if (cnt_q == wait_lim) begin
               done_o  = 1'b1;
               cnt_d   = '0;
               state_d = start_i ? BwLoad : BwIdle;
            end
         end
         default: state_d = BwIdle;
      endcase
      en_d = (state_d == BwPulse);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BwIdle;
         cnt_q   <= '0;
         data_q  <= 8'h00;
         rs_q    <= 1'b0;
         long_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         long_q  <= long_d;
         en_q    <= en_d;
      end
   end

   assign lcd_data_o = data_q;
   assign lcd_rs_o   = rs_q;
   assign lcd_en_o   = en_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// 16x2 character LCD controller: power-up wait, four init commands, then endless rewriting of
// both lines from the combinational text ROM.
module lcd_text_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned T_PWRUP  = CLK_FREQ / 50,
   parameter int unsigned T_EN     = (CLK_FREQ / 1_000_000 == 0) ? 1 : CLK_FREQ / 1_000_000,
   parameter int unsigned T_SHORT  = CLK_FREQ / 20_000,
   parameter int unsigned T_LONG   = CLK_FREQ / 500
) (
   input  logic            clk,
   input  logic            reset,
   lcd_text_ctrl_if.master bus,
   output logic            init_done,
   output logic            frame_pulse
);

   localparam int unsigned PwrW = $clog2(T_PWRUP + 1);

   top_state_e      state_q, state_d;
   logic [PwrW-1:0] pwr_cnt_q, pwr_cnt_d;
   logic [5:0]      step_q, step_d;
   logic [4:0]      rom_addr_q, rom_addr_d;
   logic            init_done_q, init_done_d;
   logic            frame_q, frame_d;
   logic            wr_start, wr_done, wr_rs, wr_long;
   logic [7:0]      wr_byte;

   always_comb begin
      state_d     = state_q;
      pwr_cnt_d   = pwr_cnt_q;
      step_d      = step_q;
      rom_addr_d  = rom_addr_q;
      init_done_d = init_done_q;
      frame_d     = 1'b0;
      wr_start    = 1'b0;
      unique case (state_q)
         TopPwrup: begin
            if (pwr_cnt_q == PwrW'(T_PWRUP - 1)) begin
               state_d  = TopSeq;
               step_d   = 6'd0;
               wr_start = 1'b1;
            end else begin
               pwr_cnt_d = pwr_cnt_q + PwrW'(1);
            end
         end
         TopSeq: begin
            // Flags are registered, so they appear alongside the following LOAD cycle.
            if (wr_done) begin
               wr_start = 1'b1;
               if (step_q == STEP_INIT_LAST) init_done_d = 1'b1;
               if (step_q == STEP_LAST) begin
                  step_d  = STEP_WRAP;
                  frame_d = 1'b1;
               end else begin
                  step_d = step_q + 6'd1;
               end
            end
         end
         default: state_d = TopPwrup;
      endcase
      if (wr_start && step_is_data(step_d)) rom_addr_d = step_rom_addr(step_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= TopPwrup;
         pwr_cnt_q   <= '0;
         step_q      <= 6'd0;
         rom_addr_q  <= 5'd0;
         init_done_q <= 1'b0;
         frame_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pwr_cnt_q   <= pwr_cnt_d;
         step_q      <= step_d;
         rom_addr_q  <= rom_addr_d;
         init_done_q <= init_done_d;
         frame_q     <= frame_d;
      end
   end

   assign wr_rs   = step_is_data(step_q);
   assign wr_byte = wr_rs ? bus.rom_data : step_cmd(step_q);
   assign wr_long = (step_q == STEP_CLEAR);

   lcd_byte_writer #(
      .T_EN    (T_EN),
      .T_SHORT (T_SHORT),
      .T_LONG  (T_LONG)
   ) u_writer (
      .clk         (clk),
      .reset       (reset),
      .start_i     (wr_start),
      .rs_i        (wr_rs),
      .byte_i      (wr_byte),
      .long_wait_i (wr_long),
      .done_o      (wr_done),
      .lcd_data_o  (bus.lcd_data),
      .lcd_rs_o    (bus.lcd_rs),
      .lcd_en_o    (bus.lcd_en)
   );

   assign bus.rom_addr = rom_addr_q;
   assign bus.lcd_rw   = 1'b0;
   assign bus.lcd_on   = 1'b1;
   assign bus.lcd_blon = 1'b1;
   assign init_done    = init_done_q;
   assign frame_pulse  = frame_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl at 1 MHz: strobe capture against a table of expected bytes and gaps,
// plus reset, init_done/frame_pulse timing and a mid-pulse reset.
module tb_lcd_text_ctrl;

   localparam int unsigned ClkFreq = 1_000_000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic init_done, frame_pulse;

   lcd_text_ctrl_if bus ();

   lcd_text_ctrl #(.CLK_FREQ(ClkFreq)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .init_done   (init_done),
      .frame_pulse (frame_pulse)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [32];
   assign bus.rom_data = rom[bus.rom_addr];

   int cyc = 0;
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   typedef struct {
      logic [7:0] data;
      logic       rs;
      int         gap;
   } vec_t;
   vec_t vec [40];

   int checks = 0;
   int errors = 0;

   int         nstr = 0;
   int         str_cyc  [64];
   logic [7:0] str_data [64];
   logic       str_rs   [64];
   logic       str_init [64];
   int         init_rise = -1;
   int         frame_cnt = 0;
   int         frame_cyc = -1;
   logic       en_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;
   logic       rs_prev = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Every wait goes through here so the monitor sees each cycle exactly once.
   task automatic tick();
      @(negedge clk);
      if (bus.lcd_en && !en_prev && nstr < 64) begin
         str_cyc[nstr]  = cyc;
         str_data[nstr] = bus.lcd_data;
         str_rs[nstr]   = bus.lcd_rs;
         str_init[nstr] = init_done;
         nstr++;
      end
      if (init_done && init_rise < 0) init_rise = cyc;
      if (frame_pulse) begin
         frame_cnt++;
         frame_cyc = cyc;
      end
      if (cyc != 0 && (bus.lcd_en || en_prev)) begin
         checks++;
         assert (bus.lcd_data == data_prev && bus.lcd_rs == rs_prev)
         else begin
            errors++;
            $display("FAIL hold at cycle %0d: data 0x%0h rs %0b, was 0x%0h rs %0b",
                     cyc, bus.lcd_data, bus.lcd_rs, data_prev, rs_prev);
         end
      end
      en_prev   = bus.lcd_en;
      data_prev = bus.lcd_data;
      rs_prev   = bus.lcd_rs;
   endtask

   task automatic wait_strobes(input int n, input int budget, input string name);
      int k = 0;
      while (nstr < n && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (nstr < n) begin
         errors++;
         $display("FAIL %s timeout: got %0d strobes, expected %0d", name, nstr, n);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " rom_addr"}, int'(bus.rom_addr), 0);
      chk({tag, " lcd_data"}, int'(bus.lcd_data), 0);
      chk({tag, " lcd_rs"}, int'(bus.lcd_rs), 0);
      chk({tag, " lcd_en"}, int'(bus.lcd_en), 0);
      chk({tag, " init_done"}, int'(init_done), 0);
      chk({tag, " frame_pulse"}, int'(frame_pulse), 0);
   endtask

   initial begin
      string l1;
      string l2;
      int    k;
      l1 = "Hello";
      l2 = "World-3";
      for (int i = 0; i < 32; i++) rom[i] = 8'h20;
      for (int i = 0; i < l1.len(); i++) rom[i] = l1[i];
      for (int i = 0; i < l2.len(); i++) rom[16 + i] = l2[i];
      rom[23] = 8'h0A;

      vec[0] = '{8'h38, 1'b0, 20002};
      vec[1] = '{8'h0C, 1'b0, 53};
      vec[2] = '{8'h01, 1'b0, 53};
      vec[3] = '{8'h06, 1'b0, 2003};
      vec[4] = '{8'h80, 1'b0, 53};
      for (int i = 0; i < 16; i++) vec[5 + i] = '{rom[i], 1'b1, 53};
      vec[21] = '{8'hC0, 1'b0, 53};
      for (int i = 0; i < 16; i++) vec[22 + i] = '{rom[16 + i], 1'b1, 53};
      vec[38] = '{8'h80, 1'b0, 53};
      vec[39] = '{rom[0], 1'b1, 53};

      repeat (3) tick();
      chk_reset_vals("reset");
      chk("reset lcd_rw", int'(bus.lcd_rw), 0);
      chk("reset lcd_on", int'(bus.lcd_on), 1);
      chk("reset lcd_blon", int'(bus.lcd_blon), 1);
      reset = 1'b0;

      wait_strobes(40, 26000, "frame");
      for (int i = 0; i < 40; i++) begin
         chk($sformatf("strobe %0d data", i), int'(str_data[i]), int'(vec[i].data));
         chk($sformatf("strobe %0d rs", i), int'(str_rs[i]), int'(vec[i].rs));
         chk($sformatf("strobe %0d gap", i),
             (i == 0) ? str_cyc[0] : str_cyc[i] - str_cyc[i - 1], vec[i].gap);
      end
      chk("init_done before step4", int'(str_init[3]), 0);
      chk("init_done at step4", int'(str_init[4]), 1);
      chk("init_done rise cycle", init_rise, 22162);
      chk("frame_pulse count", frame_cnt, 1);
      chk("frame_pulse cycle", frame_cyc, 23964);
      chk("steady frame period", str_cyc[38] - str_cyc[4], 1802);
      chk("lcd_rw steady", int'(bus.lcd_rw), 0);

      k = 0;
      while (!bus.lcd_en && k < 100) begin
         tick();
         k++;
      end
      chk("pulse found for reset", int'(bus.lcd_en), 1);
      reset = 1'b1;
      tick();
      chk_reset_vals("mid reset");
      reset = 1'b0;
      nstr      = 0;
      init_rise = -1;
      frame_cnt = 0;

      wait_strobes(1, 20100, "restart");
      chk("restart first rise cycle", str_cyc[0], 20002);
      chk("restart data", int'(str_data[0]), 8'h38);
      chk("restart rs", int'(str_rs[0]), 0);
      chk("restart init_done", int'(init_done), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
